perf_counter_bank: RTL

Synthesizable, parametrised event-counter bank that replaces the bench-only instruction and cache hit/request tallies with in-design hardware. It counts NUM_EVT single-bit event channels plus a cycle counter, freezes on processor halt, and exposes values through a snapshot (shadow) bank with a registered read port. It sits beside the processor core and is fed by retire, cache request/hit, and halt strobes.

---
 rtl/perf_counter_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// Event-counter bank: NUM_EVT event channels plus a cycle counter, counting only in RUN,
// with a snapshot shadow bank behind a registered read port and sticky overflow flags.
module perf_counter_bank #(
  parameter int NUM_EVT  = 8,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clear,
  input  logic               snap,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic [1:0]         state
);

  localparam int NC = NUM_EVT + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q    [NC];
  logic [CNT_W-1:0] cnt_d    [NC];
  logic [CNT_W-1:0] shadow_q [NC];
  logic [CNT_W-1:0] shadow_d [NC];
  logic [NUM_EVT:0] ovf_q, ovf_d;
  logic [NUM_EVT:0] inc;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             run;
  logic             snap_load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (halt)         state_d = ST_HALTED;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_HALTED: if (clear) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  // Top bit is the cycle counter, which ticks on every RUN cycle.
  assign inc       = {1'b1, evt} & {NC{run}};
  // Entering HALTED captures the counters including the halting cycle's increment.
  assign snap_load = snap | (run & halt);

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          if (SAT_MODE == 0) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      shadow_d[i] = snap_load ? cnt_d[i] : shadow_q[i];
      if (clear) begin
        cnt_d[i]    = '0;
        shadow_d[i] = '0;
      end
    end
    if (clear) ovf_d = '0;
  end

  // Reads see the shadow as it was before this edge; out-of-range selects return 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NC; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NC; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NC; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign state   = state_q;

endmodule
